// File: rtl/mips_dma_pkg.sv
// mips_dma_pkg: FSM states and bank-enable encodings shared by the DMA arbiter
package mips_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        DONE
    } state_t;

    localparam logic [1:0] BANK_DMEM = 2'b01;
    localparam logic [1:0] BANK_VRAM = 2'b10;

endpackage

// File: rtl/dma_arbiter.sv
// dma_arbiter: copies words from data memory to VGA text RAM, yielding every cycle the CPU wants the bus
module dma_arbiter
    import mips_dma_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpu_en,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [31:0]       mem_rdata0,
    output logic [1:0]        mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0]  len;
    logic [31:0]       data;
    logic              run, cpu, rd, wr;

    assign run  = state inside {READ, LATCH, WRITE};
    assign cpu  = cpu_en != 2'b00;
    assign busy = run && !rst;
    assign done = (state == DONE) && !rst;

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    // next state plus output mux; the CPU always wins, abort and reset suppress DMA accesses
    always_comb begin
        state_nxt = state;
        rd = 1'b0;
        wr = 1'b0;
        case (state)
            IDLE:    if (cfg_start) state_nxt = (cfg_len == '0) ? DONE : READ;
            READ:    if (!cpu) begin
                         rd = 1'b1;
                         state_nxt = LATCH;
                     end
            LATCH:   state_nxt = WRITE;
            WRITE:   if (!cpu) begin
                         wr = 1'b1;
                         state_nxt = (len == LEN_W'(1)) ? DONE : READ;
                     end
            default: state_nxt = IDLE;
        endcase
        if (run && cfg_abort) begin
            state_nxt = IDLE;
            rd = 1'b0;
            wr = 1'b0;
        end
        if (rst) begin
            rd = 1'b0;
            wr = 1'b0;
        end
        mem_en    = cpu ? cpu_en    : rd ? BANK_DMEM : wr ? BANK_VRAM : 2'b00;
        mem_we    = cpu ? cpu_we    : wr ? 4'hF : 4'h0;
        mem_addr  = cpu ? cpu_addr  : rd ? src : wr ? dst : '0;
        mem_wdata = cpu ? cpu_wdata : wr ? data : 32'h0;
    end

    // transfer registers: word-aligned latch on start, capture in LATCH, advance on each issued write
    always_ff @(posedge clk) begin
        if (rst) begin
            src  <= '0;
            dst  <= '0;
            len  <= '0;
            data <= '0;
        end else if (state == IDLE && cfg_start) begin
            src <= {cfg_src[ADDR_W-1:2], 2'b00};
            dst <= {cfg_dst[ADDR_W-1:2], 2'b00};
            len <= cfg_len;
        end else begin
            if (state == LATCH) data <= mem_rdata0;
            if (wr) begin
                src <= src + ADDR_W'(4);
                dst <= dst + ADDR_W'(4);
                len <= len - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed scenarios plus random traffic checked against an access-queue model
module tb_dma_arbiter;

    typedef struct {
        int          kind;
        logic [10:0] addr;
        logic [31:0] data;
    } op_t;

    localparam int K_RD = 0, K_GAP = 1, K_WR = 2, K_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpu_en;
    logic [3:0]  cpu_we;
    logic [10:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cfg_start, cfg_abort;
    logic [10:0] cfg_src, cfg_dst, cfg_len;
    logic [31:0] mem_rdata0;
    logic [1:0]  mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done;

    int checks = 0, failures = 0;
    int cyc, done_cyc, last_dma, wr_cnt;
    int wr_cyc [0:7];
    logic [10:0] wr_addr [0:7];
    logic [31:0] wr_data [0:7];
    logic busy_log [0:63];
    logic busy_any;
    op_t q[$];

    dma_arbiter #(.ADDR_W(11), .LEN_W(11)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .mem_rdata0(mem_rdata0),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [10:0] a);
        return 32'hD00D_0000 + 32'(a) * 32'h0001_0003;
    endfunction

    // data memory with synchronous read, contents fixed by rom()
    always @(posedge clk) mem_rdata0 <= rom(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0;
        done_cyc = -1;
        last_dma = -1;
        wr_cnt = 0;
        busy_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_cyc[i] = -1;
            wr_addr[i] = 11'h7FF;
            wr_data[i] = 32'h0;
        end
        for (int i = 0; i < 64; i++) busy_log[i] = 1'b0;
    endtask

    task automatic step(input logic r, input logic [1:0] ce, input logic st, input logic ab,
                        input logic [10:0] s, input logic [10:0] d, input logic [10:0] l);
        int hk;
        logic dma_rd, dma_wr, c;
        logic [10:0] a, b;
        rst = r; cpu_en = ce; cpu_we = 4'($urandom); cpu_addr = 11'($urandom);
        cpu_wdata = $urandom; cfg_start = st; cfg_abort = ab;
        cfg_src = s; cfg_dst = d; cfg_len = l;
        @(negedge clk);
        hk = (q.size() != 0) ? q[0].kind : -1;
        c = cpu_en != 2'b00;
        dma_rd = !c && !rst && !cfg_abort && hk == K_RD;
        dma_wr = !c && !rst && !cfg_abort && hk == K_WR;
        chk("mem_en", 32'(mem_en), c ? 32'(cpu_en) : dma_rd ? 32'd1 : dma_wr ? 32'd2 : 32'd0);
        chk("mem_we", 32'(mem_we), c ? 32'(cpu_we) : dma_wr ? 32'hF : 32'd0);
        chk("mem_addr", 32'(mem_addr), c ? 32'(cpu_addr) : (dma_rd || dma_wr) ? 32'(q[0].addr) : 32'd0);
        if (!dma_rd) chk("mem_wdata", mem_wdata, c ? cpu_wdata : dma_wr ? q[0].data : 32'd0);
        chk("busy", 32'(busy), 32'(!rst && hk >= K_RD && hk <= K_WR));
        chk("done", 32'(done), 32'(!rst && hk == K_DONE));
        if (!c && mem_en == 2'b10 && wr_cnt < 8) begin
            wr_cyc[wr_cnt] = cyc;
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = mem_wdata;
            wr_cnt++;
        end
        if (done) done_cyc = cyc;
        if (!c && mem_en != 2'b00) last_dma = cyc;
        if (busy) busy_any = 1'b1;
        if (cyc < 64) busy_log[cyc] = busy;
        @(posedge clk);
        if (rst) q.delete();
        else if (cfg_abort && hk >= K_RD && hk <= K_WR) q.delete();
        else if (hk == K_DONE || hk == K_GAP) void'(q.pop_front());
        else if ((hk == K_RD || hk == K_WR) && !c) void'(q.pop_front());
        else if (hk == -1 && cfg_start) begin
            a = cfg_src & 11'h7FC;
            b = cfg_dst & 11'h7FC;
            for (int k = 0; k < int'(cfg_len); k++) begin
                q.push_back('{K_RD, a + 11'(4 * k), 32'h0});
                q.push_back('{K_GAP, 11'h0, 32'h0});
                q.push_back('{K_WR, b + 11'(4 * k), rom(a + 11'(4 * k))});
            end
            q.push_back('{K_DONE, 11'h0, 32'h0});
        end
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 11'h0, 11'h0, 11'h0);
    endtask

    initial begin
        rst = 1'b1; cpu_en = 2'b00; cpu_we = 4'h0; cpu_addr = 11'h0; cpu_wdata = 32'h0;
        cfg_start = 1'b0; cfg_abort = 1'b0; cfg_src = 11'h0; cfg_dst = 11'h0; cfg_len = 11'h0;
        clear_log();
        @(posedge clk);
        #1;
        step(1'b1, 2'b00, 1'b1, 1'b0, 11'h0, 11'h0, 11'd2);
        step(1'b1, 2'b00, 1'b0, 1'b0, 11'h0, 11'h0, 11'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);

        // three-word copy, no CPU traffic
        clear_log();
        step(1'b0, 2'b00, 1'b1, 1'b0, 11'h000, 11'h000, 11'd3);
        idle(11);
        chk("basic_wr_cnt", 32'(wr_cnt), 32'd3);
        chk("basic_wr0_addr", 32'(wr_addr[0]), 32'h000);
        chk("basic_wr1_addr", 32'(wr_addr[1]), 32'h004);
        chk("basic_wr2_addr", 32'(wr_addr[2]), 32'h008);
        chk("basic_wr0_cyc", 32'(wr_cyc[0]), 32'd3);
        chk("basic_wr1_cyc", 32'(wr_cyc[1]), 32'd6);
        chk("basic_wr2_cyc", 32'(wr_cyc[2]), 32'd9);
        chk("basic_wr0_data", wr_data[0], 32'hD00D_0000);
        chk("basic_wr2_data", wr_data[2], 32'hD015_0018);
        chk("basic_done_cyc", 32'(done_cyc), 32'd10);

        // zero-length copy
        clear_log();
        step(1'b0, 2'b00, 1'b1, 1'b0, 11'h123, 11'h456, 11'd0);
        idle(4);
        chk("len0_done_cyc", 32'(done_cyc), 32'd1);
        chk("len0_busy", 32'(busy_any), 32'd0);
        chk("len0_dma", 32'(last_dma), 32'hFFFF_FFFF);

        // CPU holds the bus in cycles 1-2
        clear_log();
        step(1'b0, 2'b00, 1'b1, 1'b0, 11'h100, 11'h040, 11'd2);
        step(1'b0, 2'b01, 1'b0, 1'b0, 11'h0, 11'h0, 11'h0);
        step(1'b0, 2'b01, 1'b0, 1'b0, 11'h0, 11'h0, 11'h0);
        idle(9);
        chk("cpu_done_cyc", 32'(done_cyc), 32'd9);
        chk("cpu_wr0_cyc", 32'(wr_cyc[0]), 32'd5);
        chk("cpu_wr1_cyc", 32'(wr_cyc[1]), 32'd8);

        // destination wraps past the top of the bank, unaligned start
        clear_log();
        step(1'b0, 2'b00, 1'b1, 1'b0, 11'h022, 11'h7FE, 11'd2);
        idle(8);
        chk("wrap_wr0_addr", 32'(wr_addr[0]), 32'h7FC);
        chk("wrap_wr1_addr", 32'(wr_addr[1]), 32'h000);
        chk("wrap_done_cyc", 32'(done_cyc), 32'd7);

        // abort in cycle 4, stray start while busy
        clear_log();
        step(1'b0, 2'b00, 1'b1, 1'b0, 11'h200, 11'h300, 11'd4);
        idle(1);
        step(1'b0, 2'b00, 1'b1, 1'b0, 11'h000, 11'h600, 11'd1);
        idle(1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 11'h0, 11'h0, 11'h0);
        idle(10);
        chk("abort_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("abort_wr0_addr", 32'(wr_addr[0]), 32'h300);
        chk("abort_last_dma", 32'(last_dma), 32'd3);
        chk("abort_busy4", 32'(busy_log[4]), 32'd1);
        chk("abort_busy5", 32'(busy_log[5]), 32'd0);
        chk("abort_done", 32'(done_cyc), 32'hFFFF_FFFF);

        // reset during the first WRITE
        clear_log();
        step(1'b0, 2'b00, 1'b1, 1'b0, 11'h010, 11'h080, 11'd2);
        idle(2);
        step(1'b1, 2'b00, 1'b0, 1'b0, 11'h0, 11'h0, 11'h0);
        idle(6);
        chk("rstw_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rstw_busy4", 32'(busy_log[4]), 32'd0);
        chk("rstw_done", 32'(done_cyc), 32'hFFFF_FFFF);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'b00,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0,
                 11'($urandom), 11'($urandom), 11'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
